// File: rtl/uart_cmd_responder.sv
// Byte-protocol command responder: parses 'W' addr data / 'R' addr frames from the UART,
// drives a simple 8-bit register bus and returns one response byte per valid frame.
module uart_cmd_responder #(
    parameter int unsigned TIMEOUT = 5000000,
    parameter logic [7:0]  CMD_WR  = 8'h57,
    parameter logic [7:0]  CMD_RD  = 8'h52,
    parameter logic [7:0]  RSP_OK  = 8'h4B,
    parameter logic [7:0]  RSP_BAD = 8'h3F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_avail,
    input  logic       rx_error,
    output logic       rx_ack,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_busy,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic [7:0] err_count
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, WR_STROBE, RD_STROBE, RD_CAPTURE, RESP, RESP_WAIT
    } state_t;

    state_t        state;
    logic          mode_wr;
    logic [CW-1:0] tcnt;
    logic          byte_in;
    logic          err_in;

    // The UART drops avail/error one edge after the ack, so ignore them while acking.
    assign byte_in = rx_avail && !rx_ack;
    assign err_in  = rx_error && !rx_ack;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mode_wr   <= 1'b0;
            tcnt      <= '0;
            rx_ack    <= 1'b0;
            tx_data   <= 8'h00;
            tx_wr     <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            err_count <= 8'h00;
        end else begin
            rx_ack <= 1'b0;
            tx_wr  <= 1'b0;
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            case (state)
                IDLE: begin
                    if (err_in) begin
                        rx_ack    <= 1'b1;
                        err_count <= sat_inc(err_count);
                    end else if (byte_in) begin
                        rx_ack <= 1'b1;
                        tcnt   <= '0;
                        if (rx_data == CMD_WR) begin
                            mode_wr <= 1'b1;
                            state   <= GET_ADDR;
                        end else if (rx_data == CMD_RD) begin
                            mode_wr <= 1'b0;
                            state   <= GET_ADDR;
                        end else begin
                            tx_data   <= RSP_BAD;
                            err_count <= sat_inc(err_count);
                            state     <= RESP;
                        end
                    end
                end
                GET_ADDR, GET_DATA: begin
                    // A byte arriving on the timeout cycle wins and restarts the count.
                    if (err_in) begin
                        rx_ack    <= 1'b1;
                        err_count <= sat_inc(err_count);
                        state     <= IDLE;
                    end else if (byte_in) begin
                        rx_ack <= 1'b1;
                        tcnt   <= '0;
                        if (state == GET_ADDR) begin
                            reg_addr <= rx_data;
                            if (mode_wr) begin
                                state <= GET_DATA;
                            end else begin
                                reg_re <= 1'b1;
                                state  <= RD_STROBE;
                            end
                        end else begin
                            reg_wdata <= rx_data;
                            reg_we    <= 1'b1;
                            state     <= WR_STROBE;
                        end
                    end else if (tcnt == T_LAST) begin
                        err_count <= sat_inc(err_count);
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                WR_STROBE: begin
                    tx_data <= RSP_OK;
                    state   <= RESP;
                end
                RD_STROBE: begin
                    state <= RD_CAPTURE;
                end
                RD_CAPTURE: begin
                    tx_data <= reg_rdata;
                    state   <= RESP;
                end
                RESP: begin
                    if (!tx_busy) begin
                        tx_wr <= 1'b1;
                        state <= RESP_WAIT;
                    end
                end
                RESP_WAIT: begin
                    if (tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: directed frames push expected bus/tx events,
// a negedge monitor pops and compares them as the DUT strobes.
module tb_uart_cmd_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_error;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_busy;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    uart_cmd_responder #(.TIMEOUT(100)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error), .rx_ack(rx_ack),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .err_count(err_count)
    );

    // Register bus model: read data valid one cycle after reg_re.
    logic [7:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h22] = 8'h3C;
    end
    always @(posedge clk) begin
        if (reg_we) mem[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    // Transmitter model: goes busy the edge after tx_wr, plus a forced hold for back-pressure.
    int   busy_cnt = 0;
    logic hold_busy = 1'b0;
    always @(posedge clk) begin
        if (tx_wr) busy_cnt <= 4;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || hold_busy;

    localparam logic [1:0] EV_WE = 2'd0, EV_RE = 2'd1, EV_TX = 2'd2;
    typedef struct {
        logic [1:0] kind;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;
    ev_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int ack_cnt = 0;
    int tx_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [1:0] k, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event: got kind %0d a=%0h d=%0h expected none", k, a, d);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 64'(k), 64'(e.kind));
            check("event_field_a", 64'(a), 64'(e.a));
            check("event_field_d", 64'(d), 64'(e.d));
        end
    endtask

    // Monitor: sample strobes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            if (rx_ack) ack_cnt++;
            if (reg_we) pop_cmp(EV_WE, reg_addr, reg_wdata);
            if (reg_re) pop_cmp(EV_RE, reg_addr, 8'h00);
            if (tx_wr) begin
                tx_cnt++;
                pop_cmp(EV_TX, 8'h00, tx_data);
            end
        end
    end

    task automatic send(input bit is_err, input logic [7:0] b);
        int n = 0;
        rx_data = b;
        if (is_err) rx_error = 1'b1; else rx_avail = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (!rx_ack && n < 400);
        if (!rx_ack) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_timeout: byte %0h got no ack, expected ack within 400 cycles", b);
        end
        // Hold the level one more edge, like the real UART.
        @(posedge clk); #1;
        rx_avail = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d events pending, expected 0", exp_q.size());
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    int a0;
    int t0;

    initial begin
        reset = 1'b0; rx_data = 8'h00; rx_avail = 1'b0; rx_error = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({rx_ack, tx_wr, reg_we, reg_re, tx_data, reg_addr, reg_wdata, err_count}), 64'd0);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Write frame
        a0 = ack_cnt;
        expect_ev(EV_WE, 8'h10, 8'hA5);
        expect_ev(EV_TX, 8'h00, 8'h4B);
        send(0, 8'h57); send(0, 8'h10); send(0, 8'hA5);
        drain();
        check("write_ack_count", 64'(ack_cnt - a0), 64'd3);
        check("write_mem", 64'(mem[8'h10]), 64'hA5);

        // Read frame
        expect_ev(EV_RE, 8'h22, 8'h00);
        expect_ev(EV_TX, 8'h00, 8'h3C);
        send(0, 8'h52); send(0, 8'h22);
        drain();

        // Unknown command
        expect_ev(EV_TX, 8'h00, 8'h3F);
        send(0, 8'h41);
        drain();
        check("bad_cmd_err_count", 64'(err_count), 64'd1);

        // Framing error mid-frame, then a normal read
        a0 = ack_cnt;
        send(0, 8'h57); send(1, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("rx_error_ack_count", 64'(ack_cnt - a0), 64'd2);
        check("rx_error_err_count", 64'(err_count), 64'd2);
        expect_ev(EV_RE, 8'h22, 8'h00);
        expect_ev(EV_TX, 8'h00, 8'h3C);
        send(0, 8'h52); send(0, 8'h22);
        drain();

        // Partial frame timeout, then a fresh write
        send(0, 8'h57); send(0, 8'h10);
        repeat (110) @(posedge clk);
        #1;
        check("timeout_err_count", 64'(err_count), 64'd3);
        expect_ev(EV_WE, 8'h11, 8'h01);
        expect_ev(EV_TX, 8'h00, 8'h4B);
        send(0, 8'h57); send(0, 8'h11); send(0, 8'h01);
        drain();
        check("timeout_then_write_mem", 64'(mem[8'h11]), 64'h01);

        // Back-pressure: response withheld while transmitter busy
        hold_busy = 1'b1;
        t0 = tx_cnt;
        expect_ev(EV_WE, 8'h12, 8'h02);
        expect_ev(EV_TX, 8'h00, 8'h4B);
        send(0, 8'h57); send(0, 8'h12); send(0, 8'h02);
        repeat (500) @(posedge clk);
        #1;
        check("busy_holds_tx_wr", 64'(tx_cnt - t0), 64'd0);
        hold_busy = 1'b0;
        drain();
        check("busy_release_tx_wr", 64'(tx_cnt - t0), 64'd1);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            expect_ev(EV_TX, 8'h00, 8'h3F);
            send(0, 8'h41);
        end
        drain();
        check("err_count_saturated", 64'(err_count), 64'hFF);

        // Asynchronous reset while in GET_DATA
        send(0, 8'h57); send(0, 8'h30);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({rx_ack, tx_wr, reg_we, reg_re, tx_data, reg_addr, reg_wdata, err_count}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_ev(EV_WE, 8'h13, 8'h07);
        expect_ev(EV_TX, 8'h00, 8'h4B);
        send(0, 8'h57); send(0, 8'h13); send(0, 8'h07);
        drain();
        check("post_reset_err_count", 64'(err_count), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
